// File: rtl/mv_scale_ctrl.sv
// MV scaling sequencer: derives td/tb from raw POCs, picks bypass or the pipelined
// `scale` unit, applies the td/tb sign correction and presents the result over valid/ready.

module scale #(
   parameter int MV_W = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [14:0]            poc_diff1,
   input  logic [14:0]            poc_diff2,
   input  logic signed [MV_W-1:0] mv0,
   input  logic signed [MV_W-1:0] mv1,
   output logic signed [MV_W-1:0] mv0_scaled,
   output logic signed [MV_W-1:0] mv1_scaled,
   output logic                   scale_done
);
   localparam int PW = MV_W + 13;
   localparam logic [PW-2:0] MAXM = (PW-1)'((1 << (MV_W-1)) - 1);

   logic [7:0]              vld_q;
   logic [6:0]              td_q, tb_q, td_div;
   logic [14:0]             tx_q, tx_d;
   logic [21:0]             prod_d;
   logic [11:0]             dsf_q, dsf_d;
   logic signed [MV_W-1:0]  mv_in [2];
   logic signed [PW-1:0]    p_q [2];
   logic [PW-2:0]           m5_q [2];
   logic [MV_W-2:0]         m6_q [2], m7_q [2];
   logic signed [MV_W-1:0]  mv_out_q [2];

   assign mv_in[0]   = mv0;
   assign mv_in[1]   = mv1;
   assign mv0_scaled = mv_out_q[0];
   assign mv1_scaled = mv_out_q[1];
   assign scale_done = vld_q[7];

   always_comb begin
      td_div = (td_q == 7'd0) ? 7'd1 : td_q;
      tx_d   = 15'((15'd16384 + 15'(td_q >> 1)) / 15'(td_div));
      prod_d = 22'(tb_q) * 22'(tx_q) + 22'd32;
      dsf_d  = (prod_d[21:6] > 16'd4095) ? 12'd4095 : prod_d[17:6];
   end

   always_ff @(posedge clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= {vld_q[6:0], 1'b1};
   end

   // The MV sign is re-read from the inputs at the last stage, so they must stay stable.
   always_ff @(posedge clk) begin
      td_q  <= (poc_diff1 > 15'd127) ? 7'd127 : poc_diff1[6:0];
      tb_q  <= (poc_diff2 > 15'd127) ? 7'd127 : poc_diff2[6:0];
      tx_q  <= tx_d;
      dsf_q <= dsf_d;
      for (int i = 0; i < 2; i++) begin
         p_q[i]      <= $signed({{(PW-12){1'b0}}, dsf_q}) * PW'(mv_in[i]);
         m5_q[i]     <= ((p_q[i][PW-1] ? (PW-1)'(-p_q[i]) : (PW-1)'(p_q[i])) + (PW-1)'(127)) >> 8;
         m6_q[i]     <= (m5_q[i] > MAXM) ? MAXM[MV_W-2:0] : m5_q[i][MV_W-2:0];
         m7_q[i]     <= m6_q[i];
         mv_out_q[i] <= mv_in[i][MV_W-1] ? -$signed({1'b0, m7_q[i]}) : $signed({1'b0, m7_q[i]});
      end
   end
endmodule

module mv_scale_ctrl #(
   parameter int POC_W = 16,
   parameter int MV_W  = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [POC_W-1:0] cur_poc,
   input  logic [POC_W-1:0] tgt_ref_poc,
   input  logic [POC_W-1:0] cand_poc,
   input  logic [POC_W-1:0] cand_ref_poc,
   input  logic             long_term,
   input  logic [MV_W-1:0]  mv0_in,
   input  logic [MV_W-1:0]  mv1_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MV_W-1:0]  mv0_out,
   output logic [MV_W-1:0]  mv1_out,
   output logic             scaled
);
   typedef enum logic [2:0] {IDLE, CALC, LOAD, RUN, BYPASS, OUT} state_t;
   localparam logic signed [POC_W:0] CMAX = 127;
   localparam logic signed [POC_W:0] CMIN = -128;

   state_t                 state_q, state_d;
   logic [POC_W-1:0]       cur_q, tgt_q, cand_q, cref_q;
   logic                   lt_q, neg_q, neg_d, byp_d;
   logic signed [MV_W-1:0] mv0_q, mv1_q, mv0_scl, mv1_scl;
   logic [MV_W-1:0]        mv0_out_q, mv1_out_q;
   logic                   scaled_q, scl_rst, scl_done;
   logic [14:0]            atd_q, atb_q, atd_d, atb_d;
   logic signed [POC_W:0]  tb_raw, td_raw;
   logic signed [8:0]      tb_c, td_c;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign mv0_out   = mv0_out_q;
   assign mv1_out   = mv1_out_q;
   assign scaled    = scaled_q;
   assign scl_rst   = rst || (state_q != RUN);

   // Differences carry one extra bit so extreme POCs cannot wrap before clipping.
   always_comb begin
      tb_raw = $signed({cur_q[POC_W-1], cur_q}) - $signed({tgt_q[POC_W-1], tgt_q});
      td_raw = $signed({cand_q[POC_W-1], cand_q}) - $signed({cref_q[POC_W-1], cref_q});
      tb_c   = (tb_raw > CMAX) ? 9'sd127 : (tb_raw < CMIN) ? -9'sd128 : tb_raw[8:0];
      td_c   = (td_raw > CMAX) ? 9'sd127 : (td_raw < CMIN) ? -9'sd128 : td_raw[8:0];
      atb_d  = 15'(tb_c[8] ? -tb_c : tb_c);
      atd_d  = 15'(td_c[8] ? -td_c : td_c);
      neg_d  = tb_c[8] ^ td_c[8];
      byp_d  = lt_q || (td_c == tb_c) || (td_c == 9'sd0);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = CALC;
         CALC:    state_d = byp_d ? BYPASS : LOAD;
         LOAD:    state_d = RUN;
         RUN:     if (scl_done) state_d = OUT;
         BYPASS:  state_d = OUT;
         OUT:     if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q <= '0; tgt_q <= '0; cand_q <= '0; cref_q <= '0;
         lt_q <= 1'b0; mv0_q <= '0; mv1_q <= '0;
         atd_q <= '0; atb_q <= '0; neg_q <= 1'b0;
         mv0_out_q <= '0; mv1_out_q <= '0; scaled_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               cur_q  <= cur_poc;      tgt_q <= tgt_ref_poc;
               cand_q <= cand_poc;     cref_q <= cand_ref_poc;
               lt_q   <= long_term;
               mv0_q  <= $signed(mv0_in); mv1_q <= $signed(mv1_in);
            end
            CALC: begin
               atd_q <= atd_d; atb_q <= atb_d; neg_q <= neg_d;
            end
            BYPASS: begin
               mv0_out_q <= mv0_q; mv1_out_q <= mv1_q; scaled_q <= 1'b0;
            end
            RUN: if (scl_done) begin
               mv0_out_q <= neg_q ? MV_W'(-mv0_scl) : mv0_scl;
               mv1_out_q <= neg_q ? MV_W'(-mv1_scl) : mv1_scl;
               scaled_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   scale #(.MV_W(MV_W)) u_scale (
      .clk        (clk),
      .rst        (scl_rst),
      .poc_diff1  (atd_q),
      .poc_diff2  (atb_q),
      .mv0        (mv0_q),
      .mv1        (mv1_q),
      .mv0_scaled (mv0_scl),
      .mv1_scaled (mv1_scl),
      .scale_done (scl_done)
   );
endmodule

// File: doc/mv_scale_ctrl.md
Name: mv_scale_ctrl

Overview:
Sequencer directly upstream of the existing `scale` unit, which it instantiates and drives. It accepts one MV-pair scaling request per transaction with raw POCs, and derives td/tb per HEVC (Clip3(-128,127)). It decides bypass versus scaling, runs `scale` on magnitudes, and applies the td/tb sign correction that `scale` does not perform. Results go to the merge/AMVP candidate builder over a valid/ready handshake.

Parameters:
POC_W, 16, signed POC width; differences are computed at POC_W+1 bits.
MV_W, 15, signed MV component width; must match `scale` (15).

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE
cur_poc  in  POC_W  POC of the current picture (signed)
tgt_ref_poc  in  POC_W  POC of the target reference picture
cand_poc  in  POC_W  POC of the picture owning the candidate MV
cand_ref_poc  in  POC_W  POC of the candidate's reference picture
long_term  in  1  either reference is long-term, which forces bypass
mv0_in  in  MV_W  candidate MV x (signed)
mv1_in  in  MV_W  candidate MV y (signed)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
mv0_out  out  MV_W  resulting MV x
mv1_out  out  MV_W  resulting MV y
scaled  out  1  1 = result came through `scale`; 0 = bypass

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, mv0_out=0, mv1_out=0, scaled=0.
- Reset mid-operation aborts any transaction and drops out_valid. The internal `scale` rst is also forced high.
- FSM: IDLE -> CALC -> (LOAD -> RUN) or BYPASS -> OUT -> IDLE.
- IDLE: on in_valid && in_ready, register all inputs. Register copies stay stable until the transaction leaves OUT, because `scale` re-reads the mv sign at its last stage.
- CALC (1 cycle):
  - tb = Clip3(-128,127, cur_poc - tgt_ref_poc).
  - td = Clip3(-128,127, cand_poc - cand_ref_poc).
  - neg = sign(td) XOR sign(tb).
  - Register |td| and |tb| as 15-bit unsigned. The value 128 is permitted; `scale` saturates it to 127.
  - Bypass if long_term, td==tb, or td==0. The td==0 case is an error-robustness guard: the MV passes unchanged.
- BYPASS (1 cycle): mv*_out = registered mv*_in, scaled=0.
- LOAD (1 cycle): `scale` rst held high, with poc_diff1=|td|, poc_diff2=|tb|, mv0/mv1 = registered inputs. `scale` rst is also high in every state other than RUN.
- RUN: `scale` rst low. Wait for scale_done. On the first cycle scale_done is high:
  - mv*_out = neg ? -mv*_scaled : mv*_scaled.
  - scaled=1, go to OUT.
  - `scale` already limits its outputs to ±16383, so negation cannot overflow.
- OUT: out_valid=1 with outputs held stable until out_ready. On out_valid && out_ready go to IDLE, set out_valid=0 and in_ready=1.
- No new request is accepted in the same cycle as an output handshake.
- Latency, counted from the accepting edge to out_valid high:
  - bypass path: 2 cycles;
  - scaled path: 11 cycles (LOAD edge, 8 scale stages, done-capture edge).
- Throughput: one transaction in flight.
- Backpressure: out_ready low holds OUT indefinitely, and in_ready stays 0.
- POC differences wrap-free: computed at POC_W+1 bits before clipping.

Test Plan:
- Scaled positive: cur=8, tgt=7, cand=8, cand_ref=6, mv=(64,-32) -> tb=1, td=2, out=(32,-16), scaled=1, out_valid 11 cycles after accept.
- Sign flip: cur=8, tgt=9, cand=8, cand_ref=6, mv=(64,-32) -> tb=-1, td=2, neg=1, out=(-32,16), scaled=1.
- Bypass: td==tb=4 with mv=(100,-7) -> out=(100,-7), scaled=0, 2-cycle latency. Also long_term=1 with td=2, tb=1 -> unchanged, and td=0 -> unchanged.
- Saturation: tb=4, td=1, mv=(8000,-8000) -> out=(16383,-16383). Then tb=-4 on the same request -> out=(-16383,16383).
- Clip and backpressure:
  - cur-tgt=300, cand-cand_ref=-200 -> tb=127, td=-128, |td| saturates in `scale`.
  - Hold out_ready=0 for 20 cycles -> outputs stable, in_ready=0. Release -> exactly one handshake, then in_ready=1.
- Reset mid-RUN: assert rst 5 cycles into RUN -> next cycle out_valid=0, in_ready=1, outputs 0. A following request (mv=(64,-32), tb=1, td=2) yields (32,-16).
